// File: rtl/light_sched_pkg.sv
// Shared types and defaults for the multi-zone occupancy lighting scheduler.
package light_sched_pkg;

    // Per-zone light state
    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAIT = 2'd1,
        ON   = 2'd2,
        HOLD = 2'd3
    } zone_state_e;

    // 60 s at a 10 MHz clock
    localparam int unsigned TICK_CYCLES_DEFAULT = 600_000_000;
    localparam int unsigned DEFAULT_TIMEOUT_MIN = 5;

endpackage

// File: rtl/light_zone_fsm.sv
// One zone's light state machine: state, hold counter and timeout compare.
// Outputs are flops updated alongside the state, so they track it with no lag.
module light_zone_fsm
    import light_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_motion,
    input  logic                 i_grant,
    input  logic                 i_tick,
    input  logic                 i_force_off,
    input  logic [TIMEOUT_W-1:0] i_timeout,
    output logic                 o_light_on,
    output logic                 o_pending
);

    localparam logic [TIMEOUT_W-1:0] HOLD_MAX = '1;

    zone_state_e          r_state;
    logic [TIMEOUT_W-1:0] r_hold_cnt;
    logic                 r_light_on;
    logic                 r_pending;

    // State, hold counter and decoded outputs advance together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= OFF;
            r_hold_cnt <= '0;
            r_light_on <= 1'b0;
            r_pending  <= 1'b0;
        end else if (i_force_off) begin
            r_state    <= OFF;
            r_hold_cnt <= '0;
            r_light_on <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            case (r_state)
                OFF: begin
                    if (i_motion) begin
                        if (i_grant) begin
                            r_state    <= ON;
                            r_light_on <= 1'b1;
                        end else begin
                            r_state   <= WAIT;
                            r_pending <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // Request stays latched regardless of motion
                    if (i_grant) begin
                        r_state    <= ON;
                        r_light_on <= 1'b1;
                        r_pending  <= 1'b0;
                    end
                end
                ON: begin
                    if (!i_motion) begin
                        r_state    <= HOLD;
                        r_hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (i_motion) begin
                        r_state    <= ON;
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt >= i_timeout) begin
                        r_state    <= OFF;
                        r_light_on <= 1'b0;
                    end else if (i_tick && (r_hold_cnt != HOLD_MAX)) begin
                        r_hold_cnt <= r_hold_cnt + TIMEOUT_W'(1);
                    end
                end
                default: begin
                    r_state    <= OFF;
                    r_light_on <= 1'b0;
                    r_pending  <= 1'b0;
                end
            endcase
        end
    end

    assign o_light_on = r_light_on;
    assign o_pending  = r_pending;

endmodule

// File: rtl/light_zone_scheduler.sv
// Multi-zone occupancy lighting controller: minute prescaler, timeout table,
// power budget and round-robin grant arbiter feeding one FSM per zone.
// Optional build macro LZS_SYNC_EN adds a two-flop synchronizer per motion input.
module light_zone_scheduler
    import light_sched_pkg::*;
#(
    parameter int unsigned NUM_ZONES       = 4,
    parameter int unsigned MAX_ON          = 2,
    parameter int unsigned TICK_CYCLES     = TICK_CYCLES_DEFAULT,
    parameter int unsigned TIMEOUT_W       = 4,
    parameter int unsigned DEFAULT_TIMEOUT = DEFAULT_TIMEOUT_MIN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_ZONES-1:0]         motion_detect,
    input  logic                         force_off,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_ZONES)-1:0] cfg_zone,
    input  logic [TIMEOUT_W-1:0]         cfg_timeout,
    output logic [NUM_ZONES-1:0]         light_on,
    output logic [NUM_ZONES-1:0]         pending,
    output logic                         minute_tick
);

    localparam int unsigned ZW = $clog2(NUM_ZONES);
    localparam int unsigned PW = $clog2(TICK_CYCLES);
    localparam int unsigned CW = $clog2(NUM_ZONES + 1);

    logic [PW-1:0]        r_presc;
    logic                 r_minute_tick;
    logic [TIMEOUT_W-1:0] r_timeout [NUM_ZONES];
    logic [ZW-1:0]        r_rr;

    logic [NUM_ZONES-1:0] w_motion;
    logic [NUM_ZONES-1:0] w_light_on;
    logic [NUM_ZONES-1:0] w_pending;
    logic [NUM_ZONES-1:0] w_req;
    logic [NUM_ZONES-1:0] w_grant;
    logic [CW-1:0]        w_on_count;
    logic                 w_found;
    logic [ZW-1:0]        w_winner;
    logic [ZW-1:0]        w_sel;
    int unsigned          w_idx;

    // Free-running minute prescaler; tick flop is high while the count is at its last value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc       <= '0;
            r_minute_tick <= 1'b0;
        end else begin
            if (r_presc == PW'(TICK_CYCLES - 1)) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            r_minute_tick <= (r_presc == PW'(TICK_CYCLES - 2));
        end
    end

    // Per-zone timeout table, writable at any time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_ZONES; k++) begin
                r_timeout[k] <= TIMEOUT_W'(DEFAULT_TIMEOUT);
            end
        end else if (cfg_we && (32'(cfg_zone) < NUM_ZONES)) begin
            r_timeout[cfg_zone] <= cfg_timeout;
        end
    end

`ifdef LZS_SYNC_EN
    logic [NUM_ZONES-1:0] r_sync_q1;
    logic [NUM_ZONES-1:0] r_sync_q2;

    // Two-flop synchronizer for asynchronous sensor pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_q1 <= '0;
            r_sync_q2 <= '0;
        end else begin
            r_sync_q1 <= motion_detect;
            r_sync_q2 <= r_sync_q1;
        end
    end

    assign w_motion = r_sync_q2;
`else
    assign w_motion = motion_detect;
`endif

    // A zone requests when waiting, or when idle and seeing motion
    assign w_req = w_pending | (~w_light_on & ~w_pending & w_motion);

    // Lit-zone count from registered state, so a slot freed this edge is usable next cycle
    always_comb begin
        w_on_count = '0;
        for (int unsigned k = 0; k < NUM_ZONES; k++) begin
            w_on_count = w_on_count + CW'(w_light_on[k]);
        end
    end

    // Round-robin search from r_rr; at most one grant, none during force_off
    always_comb begin
        w_grant  = '0;
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        w_sel    = '0;
        if (!force_off && (w_on_count < CW'(MAX_ON))) begin
            for (int unsigned k = 0; k < NUM_ZONES; k++) begin
                w_idx = 32'(r_rr) + k;
                if (w_idx >= NUM_ZONES) begin
                    w_idx = w_idx - NUM_ZONES;
                end
                w_sel = ZW'(w_idx);
                if (!w_found && w_req[w_sel]) begin
                    w_found        = 1'b1;
                    w_winner       = w_sel;
                    w_grant[w_sel] = 1'b1;
                end
            end
        end
    end

    // Pointer moves just past the winner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= '0;
        end else if (w_found) begin
            r_rr <= (32'(w_winner) == NUM_ZONES - 1) ? '0 : w_winner + ZW'(1);
        end
    end

    for (genvar g = 0; g < NUM_ZONES; g++) begin : g_zone
        light_zone_fsm #(
            .TIMEOUT_W (TIMEOUT_W)
        ) u_fsm (
            .clk         (clk),
            .rst         (rst),
            .i_motion    (w_motion[g]),
            .i_grant     (w_grant[g]),
            .i_tick      (r_minute_tick),
            .i_force_off (force_off),
            .i_timeout   (r_timeout[g]),
            .o_light_on  (w_light_on[g]),
            .o_pending   (w_pending[g])
        );
    end

    assign light_on    = w_light_on;
    assign pending     = w_pending;
    assign minute_tick = r_minute_tick;

endmodule

// File: tb/tb_light_zone_scheduler.sv
// Scoreboard bench for light_zone_scheduler (TICK_CYCLES=10, 4 zones, budget 2).
// The driver queues hand-computed expectations tagged with a cycle number;
// the monitor checks them, and the minute tick, on every falling edge.
module tb_light_zone_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] motion_detect = '0;
    logic       force_off = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_zone = '0;
    logic [3:0] cfg_timeout = '0;
    logic [3:0] light_on;
    logic [3:0] pending;
    logic       minute_tick;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc;

    typedef struct {
        int         cyc;
        logic [3:0] lo;
        logic [3:0] pd;
        string      nm;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    light_zone_scheduler #(
        .NUM_ZONES       (4),
        .MAX_ON          (2),
        .TICK_CYCLES     (10),
        .TIMEOUT_W       (4),
        .DEFAULT_TIMEOUT (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .motion_detect (motion_detect),
        .force_off     (force_off),
        .cfg_we        (cfg_we),
        .cfg_zone      (cfg_zone),
        .cfg_timeout   (cfg_timeout),
        .light_on      (light_on),
        .pending       (pending),
        .minute_tick   (minute_tick)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release: cycle n follows the n-th rising edge
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: tick phase every cycle, queued light/pending expectations when due
    always @(negedge clk) begin
        if (!rst) begin
            n_vec++;
            if (minute_tick !== ((cyc % 10) == 9)) begin
                n_fail++;
                $display("FAIL minute_tick cyc=%0d: got %b, expected %b", cyc, minute_tick, ((cyc % 10) == 9));
            end
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                mon_e = sb_q.pop_front();
                n_vec++;
                if (mon_e.cyc != cyc || light_on !== mon_e.lo || pending !== mon_e.pd) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d (due %0d): light_on=%b pending=%b, expected light_on=%b pending=%b",
                             mon_e.nm, cyc, mon_e.cyc, light_on, pending, mon_e.lo, mon_e.pd);
                end
            end
        end
    end

    task automatic step_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_at(input int c, input logic [3:0] lo, input logic [3:0] pd, input string nm);
        exp_t e;
        e.cyc = c;
        e.lo  = lo;
        e.pd  = pd;
        e.nm  = nm;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() > 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (sb_q.size() > 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: %0d expectations never reached, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Leaves the driver 1 time unit into cycle 0
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst           = 1'b1;
        motion_detect = '0;
        force_off     = 1'b0;
        cfg_we        = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Single zone, default timeout 5
        do_reset();
        expect_at(0, 4'b0000, 4'b0000, "reset_state");
        motion_detect = 4'b0001;
        expect_at(1,  4'b0001, 4'b0000, "single_on_latency");
        expect_at(3,  4'b0001, 4'b0000, "single_on_motion");
        expect_at(50, 4'b0001, 4'b0000, "single_hold_before_5th");
        expect_at(51, 4'b0000, 4'b0000, "single_off_after_5th");
        step_to(3);
        motion_detect = 4'b0000;
        step_to(52);
        drain();

        // Budget: three zones request together, third waits for a release
        do_reset();
        motion_detect = 4'b0111;
        expect_at(1, 4'b0001, 4'b0110, "budget_grant_z0");
        expect_at(2, 4'b0011, 4'b0100, "budget_grant_z1");
        step_to(3);
        motion_detect = 4'b0110;
        expect_at(50, 4'b0011, 4'b0100, "budget_z2_still_pending");
        expect_at(51, 4'b0010, 4'b0100, "budget_z0_released");
        expect_at(52, 4'b0110, 4'b0000, "budget_z2_granted");
        step_to(53);
        drain();

        // Round-robin: rr=2 retained across force_off, zones 1 and 3 compete
        do_reset();
        motion_detect = 4'b0001;
        expect_at(1, 4'b0001, 4'b0000, "rr_setup_z0");
        step_to(1);
        motion_detect = 4'b0011;
        expect_at(2, 4'b0011, 4'b0000, "rr_setup_z1");
        step_to(2);
        force_off     = 1'b1;
        motion_detect = 4'b0000;
        expect_at(3, 4'b0000, 4'b0000, "rr_setup_clear");
        step_to(3);
        force_off     = 1'b0;
        motion_detect = 4'b1010;
        expect_at(4, 4'b1000, 4'b0010, "rr_first_z3");
        expect_at(5, 4'b1010, 4'b0000, "rr_then_z1");
        step_to(6);
        drain();

        // Retrigger from HOLD with hold_cnt=3 restarts the full timeout
        do_reset();
        motion_detect = 4'b0001;
        expect_at(1, 4'b0001, 4'b0000, "retrig_on");
        step_to(1);
        motion_detect = 4'b0000;
        expect_at(31, 4'b0001, 4'b0000, "retrig_in_hold");
        step_to(32);
        motion_detect = 4'b0001;
        step_to(33);
        motion_detect = 4'b0000;
        expect_at(51, 4'b0001, 4'b0000, "retrig_no_early_off");
        expect_at(80, 4'b0001, 4'b0000, "retrig_hold_last");
        expect_at(81, 4'b0000, 4'b0000, "retrig_off");
        step_to(82);
        drain();

        // Config: lower timeout mid-HOLD, then timeout 0 gives a one-cycle HOLD
        do_reset();
        motion_detect = 4'b0001;
        step_to(1);
        motion_detect = 4'b0000;
        expect_at(1, 4'b0001, 4'b0000, "cfg_on");
        step_to(22);
        cfg_we      = 1'b1;
        cfg_zone    = 2'd0;
        cfg_timeout = 4'd1;
        expect_at(23, 4'b0001, 4'b0000, "cfg_write_cycle");
        expect_at(24, 4'b0000, 4'b0000, "cfg_lowered_off");
        step_to(23);
        cfg_we = 1'b0;
        step_to(24);
        cfg_we      = 1'b1;
        cfg_timeout = 4'd0;
        step_to(25);
        cfg_we = 1'b0;
        step_to(26);
        motion_detect = 4'b0001;
        expect_at(26, 4'b0000, 4'b0000, "t0_idle");
        expect_at(27, 4'b0001, 4'b0000, "t0_on");
        expect_at(28, 4'b0001, 4'b0000, "t0_hold_one_cycle");
        expect_at(29, 4'b0000, 4'b0000, "t0_off");
        step_to(27);
        motion_detect = 4'b0000;
        step_to(30);
        drain();

        // force_off with two lit and one pending; motion ignored while held
        do_reset();
        motion_detect = 4'b0111;
        expect_at(1, 4'b0001, 4'b0110, "force_setup_1");
        expect_at(2, 4'b0011, 4'b0100, "force_setup_2");
        step_to(2);
        force_off = 1'b1;
        expect_at(3, 4'b0000, 4'b0000, "force_clear");
        expect_at(4, 4'b0000, 4'b0000, "force_ignores_motion");
        step_to(4);
        force_off = 1'b0;
        expect_at(5, 4'b0100, 4'b0011, "force_after_rr_z2");
        expect_at(6, 4'b0101, 4'b0010, "force_after_rr_z0");
        step_to(7);
        drain();

        // Asynchronous reset mid-HOLD restores the default timeout
        do_reset();
        motion_detect = 4'b0001;
        cfg_we        = 1'b1;
        cfg_zone      = 2'd0;
        cfg_timeout   = 4'd9;
        step_to(1);
        motion_detect = 4'b0000;
        cfg_we        = 1'b0;
        expect_at(5, 4'b0001, 4'b0000, "pre_reset_hold");
        step_to(6);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (light_on !== 4'b0000 || pending !== 4'b0000 || minute_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: light_on=%b pending=%b tick=%b, expected all 0",
                     light_on, pending, minute_tick);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        motion_detect = 4'b0001;
        expect_at(1, 4'b0001, 4'b0000, "post_reset_on");
        step_to(1);
        motion_detect = 4'b0000;
        expect_at(50, 4'b0001, 4'b0000, "restored_timeout_hold");
        expect_at(51, 4'b0000, 4'b0000, "restored_timeout_off");
        step_to(52);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: bench still running at time %0t, expected completion", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
